// File: rtl/fpu_mult_initiator.sv
// fpu_mult_initiator
//   Clocked initiator for the asynchronous FP16 multiplier's four-phase
//   req/ack/valid handshake. A single-cycle start latches the operands and
//   raises mult_req. The operands stay on mult_a/mult_b while the request is
//   outstanding. ack and valid are brought into the clock domain through
//   SYNC_STAGES flops each. Once both are seen, the product is captured and
//   the request is dropped. The block then waits for ack to fall, which
//   completes the return-to-zero phase. A saturating 8-bit counter aborts a
//   stalled REQ or REL phase after TIMEOUT_CYCLES cycles.
//
//   Optional build macro FPU_MULT_INIT_QUEUE_EN adds a one-entry pending
//   slot. A start that arrives while the block is busy is stored in the slot
//   and launched when the block is idle again. When the macro is undefined,
//   there is no slot and a start that arrives while busy is ignored.
//
// Ports
//   clk, rst_n         clock; synchronous active-low reset
//   start, op_a, op_b  launch strobe and operands (sampled with start)
//   ready              a start this cycle will be accepted
//   busy               handshake in flight (state != IDLE)
//   done               1-cycle pulse; result_out was updated
//   result_out         last captured product
//   timeout_err        sticky abort flag, cleared by the next launch
//   mult_req/a/b       request and held operands to the multiplier
//   mult_result        product from the multiplier (sampled on synced valid)
//   mult_valid/ack     asynchronous responses from the multiplier
module fpu_mult_initiator #(
  parameter int DATA_W         = 16,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result_out,
  output logic              timeout_err,
  output logic              mult_req,
  output logic [DATA_W-1:0] mult_a,
  output logic [DATA_W-1:0] mult_b,
  input  logic [DATA_W-1:0] mult_result,
  input  logic              mult_valid,
  input  logic              mult_ack
);

  localparam logic [7:0] CNT_MAX = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_REL} state_t;

  state_t state, nxt_state;

  logic [SYNC_STAGES-1:0] ack_sync, valid_sync;
  logic                   ack_s, valid_s;
  logic [7:0]             cnt;
  logic                   cnt_hit;

  // strobes decoded from state + synced handshake
  logic              do_launch, do_capture, do_abort_req;
  logic              do_done, do_abort_rel, do_cnt_inc;
  logic [DATA_W-1:0] launch_a, launch_b;

  // ---------------------------------------------------------------
  // Synchronisers for the asynchronous responses
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack_sync   <= '0;
      valid_sync <= '0;
    end else begin
      ack_sync   <= {ack_sync[SYNC_STAGES-2:0], mult_ack};
      valid_sync <= {valid_sync[SYNC_STAGES-2:0], mult_valid};
    end
  end

  assign ack_s   = ack_sync[SYNC_STAGES-1];
  assign valid_s = valid_sync[SYNC_STAGES-1];
  assign cnt_hit = (cnt == CNT_MAX);

  // ---------------------------------------------------------------
  // Launch source: the direct start port, or the pending slot
  // ---------------------------------------------------------------
`ifdef FPU_MULT_INIT_QUEUE_EN
  logic              pend_v;
  logic [DATA_W-1:0] pend_a, pend_b;
  logic              slot_go, direct_go, store;

  // The slot takes priority over the port. A start that arrives in the same
  // cycle as a slot launch refills the slot.
  assign slot_go   = (state == S_IDLE) & pend_v & ~ack_s;
  assign direct_go = (state == S_IDLE) & start & ~pend_v & ~ack_s;
  assign store     = start & (~pend_v | slot_go) & ~direct_go;
  assign do_launch = slot_go | direct_go;
  assign launch_a  = slot_go ? pend_a : op_a;
  assign launch_b  = slot_go ? pend_b : op_b;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_v <= 1'b0;
      pend_a <= '0;
      pend_b <= '0;
    end else if (store) begin
      pend_v <= 1'b1;
      pend_a <= op_a;
      pend_b <= op_b;
    end else if (slot_go) begin
      pend_v <= 1'b0;
    end
  end

  assign ready = ~pend_v;
`else
  // A stale ack left over from an aborted handshake blocks new requests
  // until the ack has fully dropped.
  assign do_launch = (state == S_IDLE) & start & ~ack_s;
  assign launch_a  = op_a;
  assign launch_b  = op_b;
  assign ready     = (state == S_IDLE) & ~ack_s;
`endif

  assign busy = (state != S_IDLE);

  // ---------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt_state;
  end

  // ---------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------
  always_comb begin
    nxt_state = state;
    case (state)
      S_IDLE: if (do_launch) nxt_state = S_REQ;
      S_REQ: begin
        if (ack_s & valid_s) nxt_state = S_REL;
        else if (cnt_hit)    nxt_state = S_IDLE;
      end
      S_REL: begin
        if (!ack_s)       nxt_state = S_IDLE;
        else if (cnt_hit) nxt_state = S_IDLE;
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------
  // FSM: output strobes
  // ---------------------------------------------------------------
  always_comb begin
    do_capture   = 1'b0;
    do_abort_req = 1'b0;
    do_done      = 1'b0;
    do_abort_rel = 1'b0;
    do_cnt_inc   = 1'b0;
    case (state)
      S_REQ: begin
        if (ack_s & valid_s) do_capture   = 1'b1;
        else if (cnt_hit)    do_abort_req = 1'b1;
        else                 do_cnt_inc   = 1'b1;
      end
      S_REL: begin
        if (!ack_s)       do_done      = 1'b1;
        else if (cnt_hit) do_abort_rel = 1'b1;
        else              do_cnt_inc   = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------
  // Registered outputs and the timeout counter
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mult_req    <= 1'b0;
      mult_a      <= '0;
      mult_b      <= '0;
      result_out  <= '0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      cnt         <= '0;
    end else begin
      done <= do_done;
      if (do_launch) begin
        mult_a      <= launch_a;
        mult_b      <= launch_b;
        mult_req    <= 1'b1;
        timeout_err <= 1'b0;
        cnt         <= '0;
      end
      if (do_capture) begin
        result_out <= mult_result;
        mult_req   <= 1'b0;
        cnt        <= '0;
      end
      if (do_abort_req) begin
        mult_req    <= 1'b0;
        timeout_err <= 1'b1;
      end
      if (do_abort_rel) timeout_err <= 1'b1;
      // An increment only happens below CNT_MAX, so the counter saturates
      // and never wraps.
      if (do_cnt_inc) cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_fpu_mult_initiator.sv
// tb_fpu_mult_initiator
//   Scoreboard bench for fpu_mult_initiator. A behavioural responder models
//   the multiplier. It can answer with zero delay, answer after a delay,
//   never answer, or hold ack high. Expected products are pushed when a
//   start is driven and popped on every done pulse.
module tb_fpu_mult_initiator;

  localparam int DW   = 16;
  localparam int SYNC = 2;
  localparam int TO   = 255;

  logic          clk = 1'b0;
  logic          rst_n, start;
  logic [DW-1:0] op_a, op_b;
  logic          ready, busy, done, timeout_err, mult_req, mult_valid, mult_ack;
  logic [DW-1:0] result_out, mult_a, mult_b, mult_result;

  fpu_mult_initiator #(.DATA_W(DW), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .ready(ready), .busy(busy), .done(done), .result_out(result_out),
    .timeout_err(timeout_err), .mult_req(mult_req), .mult_a(mult_a),
    .mult_b(mult_b), .mult_result(mult_result), .mult_valid(mult_valid),
    .mult_ack(mult_ack)
  );

  always #5 clk = ~clk;

  // ---------------- responder model ----------------
  logic zero_mode, no_ack, no_valid, sticky, ack_r;
  int   dly, dcnt;

  function automatic logic [DW-1:0] prod(input logic [DW-1:0] a, input logic [DW-1:0] b);
    case ({a, b})
      {16'h3C00, 16'h4000}: prod = 16'h4000;  // 1.0 * 2.0
      {16'hC200, 16'h3800}: prod = 16'hBE00;  // -3.0 * 0.5
      {16'h4000, 16'h4000}: prod = 16'h4400;  // 2.0 * 2.0
      {16'h4200, 16'h4000}: prod = 16'h4600;  // 3.0 * 2.0
      {16'h3C00, 16'h3C00}: prod = 16'h3C00;  // 1.0 * 1.0
      default:              prod = 16'h7E00;
    endcase
  endfunction

  always @(posedge clk) begin
    if (mult_req && !no_ack) begin
      if (dcnt >= dly) ack_r <= 1'b1;
      else             dcnt  <= dcnt + 1;
    end else if (!mult_req) begin
      dcnt <= 0;
      if (!sticky) ack_r <= 1'b0;
    end
  end

  assign mult_ack    = zero_mode ? mult_req : ack_r;
  assign mult_valid  = zero_mode ? mult_req : (ack_r & ~no_valid);
  assign mult_result = mult_valid ? prod(mult_a, mult_b) : '0;

  // ---------------- checking / scoreboard ----------------
  int            checks = 0, errors = 0, done_cnt = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (exp_q.size() == 0) check("done_unexpected", 32'd1, 32'd0);
      else                   check("result", 32'(result_out), 32'(exp_q.pop_front()));
    end
  end

  // Drive one start pulse; returns after the accepting edge at the next negedge.
  task automatic pulse_start(input logic [DW-1:0] a, input logic [DW-1:0] b);
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait for done within a cycle budget; expiry is a failed comparison.
  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  initial begin
    int n, base;
    rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0;
    zero_mode = 1'b1; no_ack = 1'b0; no_valid = 1'b0; sticky = 1'b0;
    ack_r = 1'b0; dly = 0; dcnt = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req", 32'(mult_req), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_terr", 32'(timeout_err), 32'd0);
    check("rst_result", 32'(result_out), 32'd0);
    check("rst_mult_a", 32'(mult_a), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", 32'(ready), 32'd1);

    // T1: zero-delay responder; count cycles from the start cycle to done.
    start = 1'b1; op_a = 16'h3C00; op_b = 16'h4000;
    exp_q.push_back(16'h4000);
    n = 0;
    do begin
      @(posedge clk); n++;
      @(negedge clk); start = 1'b0;
    end while (!done && n < 50);
    check("t1_latency", 32'(n), 32'(2*SYNC+3));
    @(negedge clk);
    check("t1_done_width", 32'(done), 32'd0);
    check("t1_ready", 32'(ready), 32'd1);

    // T2: responder delayed 5 cycles; operands must stay stable while requesting.
    zero_mode = 1'b0; dly = 5;
    pulse_start(16'hC200, 16'h3800);
    exp_q.push_back(16'hBE00);
    check("t2_busy", 32'(busy), 32'd1);
    n = 0;
    while (!done && n < 100) begin
      if (mult_req) check("t2_mult_a_hold", 32'(mult_a), 32'h0000C200);
      @(negedge clk); n++;
    end
    check("t2_done_seen", 32'(done), 32'd1);
    @(negedge clk);
    check("t2_done_count", 32'(done_cnt), 32'd2);
    check("t2_done_width", 32'(done), 32'd0);

    // T3: never acknowledged; abort after the counter reaches TIMEOUT_CYCLES.
    no_ack = 1'b1;
    @(negedge clk);
    start = 1'b1; op_a = 16'h4000; op_b = 16'h4000;
    n = 0;
    do begin
      @(posedge clk); n++;
      @(negedge clk); start = 1'b0;
    end while (!timeout_err && n < 400);
    check("t3_timeout_cycle", 32'(n), 32'(TO+2));
    check("t3_req_dropped", 32'(mult_req), 32'd0);
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_result_kept", 32'(result_out), 32'h0000BE00);
    @(negedge clk);
    check("t3_no_done", 32'(done_cnt), 32'd2);
    check("t3_terr_sticky", 32'(timeout_err), 32'd1);

    // T4: start while busy.
    no_ack = 1'b0; dly = 3;
    base = done_cnt;
    pulse_start(16'h4200, 16'h4000);
    exp_q.push_back(16'h4600);
    check("t4_terr_cleared", 32'(timeout_err), 32'd0);
    @(negedge clk);
    start = 1'b1; op_a = 16'h3C00; op_b = 16'h3C00;
`ifdef FPU_MULT_INIT_QUEUE_EN
    exp_q.push_back(16'h3C00);
`endif
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      if (mult_req) check("t4_mult_a_hold", 32'(mult_a), 32'h00004200);
      @(negedge clk); n++;
    end
    repeat (40) @(negedge clk);
`ifdef FPU_MULT_INIT_QUEUE_EN
    check("t4_done_count", 32'(done_cnt - base), 32'd2);
`else
    check("t4_done_count", 32'(done_cnt - base), 32'd1);
`endif
    check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

    // T5: reset asserted while in REQ.
    dly = 20;
    pulse_start(16'h3C00, 16'h4000);
    repeat (3) @(negedge clk);
    check("t5_in_req", 32'(mult_req), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_req", 32'(mult_req), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_terr", 32'(timeout_err), 32'd0);
    check("t5_result", 32'(result_out), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // T6: ack acknowledged but held high with no valid; abort, then stale ack blocks.
    no_valid = 1'b1; sticky = 1'b1; dly = 2;
    pulse_start(16'h4000, 16'h4000);
    n = 0;
    while (!timeout_err && n < 400) begin
      @(negedge clk); n++;
    end
    check("t6_timeout", 32'(timeout_err), 32'd1);
    check("t6_ack_high", 32'(mult_ack), 32'd1);
    check("t6_ready_low", 32'(ready), 32'd0);
    start = 1'b1; op_a = 16'h3C00; op_b = 16'h3C00;
    repeat (3) begin
      @(negedge clk);
      check("t6_start_ignored", 32'({busy, mult_req}), 32'd0);
    end
    start = 1'b0;
    sticky = 1'b0;
    n = 0;
    while (mult_ack && n < 10) begin
      @(negedge clk); n++;
    end
    check("t6_ack_released", 32'(mult_ack), 32'd0);
    check("t6_ready_still_low", 32'(ready), 32'd0);
    n = 0;
    while (!ready && n < 20) begin
      @(posedge clk); n++;
      @(negedge clk);
    end
    check("t6_ready_delay", 32'(n), 32'(SYNC));
    check("t6_no_done", 32'(done_cnt), 32'(base + 1
`ifdef FPU_MULT_INIT_QUEUE_EN
      + 1
`endif
    ));

    // Recovery: a normal transaction clears timeout_err and completes.
    zero_mode = 1'b1; no_valid = 1'b0;
    pulse_start(16'h3C00, 16'h4000);
    exp_q.push_back(16'h4000);
    check("rec_terr_cleared", 32'(timeout_err), 32'd0);
    wait_done("rec_done", 50);
    @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
